data_process: RTL and testbench

DATA_PROCESS -- requirements
Module: data_process

---
 rtl/data_process_pkg.sv | 47 ++++
 rtl/data_process_dp_lane.sv | 45 ++++
 rtl/data_process.sv | 154 +++++++++++++++
 tb/tb_data_process.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_process_pkg.sv
// Shared constants for the line-padding byte extractor: lane count, line length, op codes.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Contents: op encodings, FSM state codes, byte-select codes, per-op beat table.
package data_process_pkg;

   localparam int DP_SRAM_NUM = 8;                // 16-bit SRAM lanes, two packed bytes each
   localparam int DP_COL      = 16;               // payload beats per line
   localparam int DP_LINE_LEN = DP_COL + 2;       // one pad beat on each side

   localparam logic [2:0] OP_IDLE    = 3'd0;
   localparam logic [2:0] OP_ZERO3   = 3'd1;
   localparam logic [2:0] OP_PAD_FWD = 3'd2;
   localparam logic [2:0] OP_PAD_BWD = 3'd3;
   localparam logic [2:0] OP_ZERO1   = 3'd4;
   localparam logic [2:0] OP_FRONT   = 3'd5;
   localparam logic [2:0] OP_BACK    = 3'd6;
   localparam logic [2:0] OP_ILLEGAL = 3'd7;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_EMIT1 = 2'd1;
   localparam logic [1:0] ST_EMIT2 = 2'd2;
   localparam logic [1:0] ST_EMIT3 = 2'd3;

   localparam logic [1:0] BSEL_ZERO = 2'd0;
   localparam logic [1:0] BSEL_HI   = 2'd1;       // word[15:8]
   localparam logic [1:0] BSEL_LO   = 2'd2;       // word[7:0]

   function automatic logic is_three_beat(input logic [2:0] op);
      return (op == OP_ZERO3) || (op == OP_PAD_FWD) || (op == OP_PAD_BWD);
   endfunction

   // Which byte of the word a given beat (0..2) of an op carries.
   function automatic logic [1:0] beat_bsel(input logic [2:0] op, input logic [1:0] idx);
      logic [1:0] bsel;
      bsel = BSEL_ZERO;
      case (op)
         OP_PAD_FWD: bsel = (idx == 2'd0) ? BSEL_ZERO : (idx == 2'd1) ? BSEL_HI : BSEL_LO;
         OP_PAD_BWD: bsel = (idx == 2'd0) ? BSEL_HI : (idx == 2'd1) ? BSEL_LO : BSEL_ZERO;
         OP_FRONT:   bsel = BSEL_HI;
         OP_BACK:    bsel = BSEL_LO;
         default:    bsel = BSEL_ZERO;
      endcase
      return bsel;
   endfunction

endpackage

// File: rtl/data_process_dp_lane.sv
// One SRAM lane: selects source word, holds it for later beats, muxes out one byte.
// Latency: byte_out is combinational; the hold register loads on the edge where load=1.
// Backpressure: none; sequencing is owned by the parent FSM.
// Ports: word_a/word_b source words, src_b picks word_b, load captures the word,
//        use_hold muxes from the held word, bsel picks zero/high/low byte, byte_out result.
module dp_lane
   import data_process_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] word_a,
   input  logic [15:0] word_b,
   input  logic        src_b,
   input  logic        load,
   input  logic        use_hold,
   input  logic [1:0]  bsel,
   output logic [7:0]  byte_out
);

   logic [15:0] hold_d, hold_q;
   logic [15:0] word_sel;
   logic [15:0] src_word;

   always_comb begin
      word_sel = src_b ? word_b : word_a;
      hold_d   = load ? word_sel : hold_q;
      // The first beat comes straight off the SRAM port; later beats reuse the held copy
      // because the SRAM output is not guaranteed stable past the capture edge.
      src_word = use_hold ? hold_q : word_sel;
      case (bsel)
         BSEL_HI: byte_out = src_word[15:8];
         BSEL_LO: byte_out = src_word[7:0];
         default: byte_out = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_q <= 16'h0000;
      end else begin
         hold_q <= hold_d;
      end
   end

endmodule

// File: rtl/data_process.sv
// Turns packed 16-bit SRAM words into padded byte beats for every lane in parallel.
// Latency: first beat one edge after the op is accepted; 3-beat ops issue back-to-back gap-free.
// Backpressure: cmd_ready low for two cycles after a 3-beat op; ops offered while low are dropped.
// Ports: data_process_reg op code, sram_sel1/sram_sel2 source selects, QB_1/QB_2/Q1_ir/Q2_ir
//        SRAM read data; pix_out/ir_out beats with pix_valid, line_done end-of-line, err_op sticky.
module data_process
   import data_process_pkg::*;
#(
   parameter int SRAM_NUM = DP_SRAM_NUM,
   parameter int LINE_LEN = DP_LINE_LEN
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [2:0]              data_process_reg,
   input  logic                    sram_sel1,
   input  logic                    sram_sel2,
   input  logic [SRAM_NUM*16-1:0]  QB_1,
   input  logic [SRAM_NUM*16-1:0]  QB_2,
   input  logic [SRAM_NUM*16-1:0]  Q1_ir,
   input  logic [SRAM_NUM*16-1:0]  Q2_ir,
   output logic                    cmd_ready,
   output logic [SRAM_NUM*8-1:0]   pix_out,
   output logic [SRAM_NUM*8-1:0]   ir_out,
   output logic                    pix_valid,
   output logic                    line_done,
   output logic                    err_op
);

   localparam int CNT_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_LEN - 1);

   logic [1:0]            state_d, state_q;
   logic                  pend_vld_d, pend_vld_q;
   logic [2:0]            op_d, op_q;
   logic                  sel1_d, sel1_q;
   logic                  sel2_d, sel2_q;
   logic                  err_d, err_q;
   logic [CNT_W-1:0]      cnt_d, cnt_q;
   logic [SRAM_NUM*8-1:0] pix_out_d, pix_out_q;
   logic [SRAM_NUM*8-1:0] ir_out_d, ir_out_q;
   logic                  pix_valid_d, pix_valid_q;
   logic                  line_done_d, line_done_q;

   logic                  accept;
   logic                  late_beat;
   logic                  beat;
   logic [1:0]            bsel;
   logic [SRAM_NUM*8-1:0] pix_byte;
   logic [SRAM_NUM*8-1:0] ir_byte;

   always_comb begin
      cmd_ready = (state_q == ST_IDLE) || (state_q == ST_EMIT3);
      accept    = cmd_ready && (data_process_reg != OP_IDLE);

      // pend_vld_q marks the edge carrying an op's first beat; it can only be set from
      // IDLE/EMIT3, so it never overlaps the EMIT2/EMIT3 follow-on beats.
      late_beat = (state_q == ST_EMIT2) || (state_q == ST_EMIT3);
      beat      = pend_vld_q || late_beat;

      // op_q is only rewritten on accept; at an EMIT3 edge that also accepts, the
      // outgoing beat still decodes the old op because this reads the current value.
      if (pend_vld_q) begin
         bsel = beat_bsel(op_q, 2'd0);
      end else if (state_q == ST_EMIT2) begin
         bsel = beat_bsel(op_q, 2'd1);
      end else begin
         bsel = beat_bsel(op_q, 2'd2);
      end

      op_d       = accept ? data_process_reg : op_q;
      sel1_d     = accept ? sram_sel1 : sel1_q;
      sel2_d     = accept ? sram_sel2 : sel2_q;
      pend_vld_d = accept && (data_process_reg != OP_ILLEGAL);
      err_d      = err_q || (accept && (data_process_reg == OP_ILLEGAL));

      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = (accept && is_three_beat(data_process_reg)) ? ST_EMIT1 : ST_IDLE;
         ST_EMIT1: state_d = ST_EMIT2;
         ST_EMIT2: state_d = ST_EMIT3;
         ST_EMIT3: state_d = (accept && is_three_beat(data_process_reg)) ? ST_EMIT1 : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      pix_valid_d = beat;
      line_done_d = beat && (cnt_q == CNT_LAST);
      cnt_d       = cnt_q;
      if (beat) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
      pix_out_d = beat ? pix_byte : pix_out_q;
      ir_out_d  = beat ? ir_byte  : ir_out_q;
   end

   for (genvar k = 0; k < SRAM_NUM; k++) begin : g_lane
      dp_lane u_pix (
         .clk      (clk),
         .rst_n    (rst_n),
         .word_a   (QB_1[16*k +: 16]),
         .word_b   (QB_2[16*k +: 16]),
         .src_b    (sel1_q),
         .load     (pend_vld_q),
         .use_hold (late_beat),
         .bsel     (bsel),
         .byte_out (pix_byte[8*k +: 8])
      );
      dp_lane u_ir (
         .clk      (clk),
         .rst_n    (rst_n),
         .word_a   (Q1_ir[16*k +: 16]),
         .word_b   (Q2_ir[16*k +: 16]),
         .src_b    (sel2_q),
         .load     (pend_vld_q),
         .use_hold (late_beat),
         .bsel     (bsel),
         .byte_out (ir_byte[8*k +: 8])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         pend_vld_q  <= 1'b0;
         op_q        <= OP_IDLE;
         sel1_q      <= 1'b0;
         sel2_q      <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         pix_out_q   <= '0;
         ir_out_q    <= '0;
         pix_valid_q <= 1'b0;
         line_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_vld_q  <= pend_vld_d;
         op_q        <= op_d;
         sel1_q      <= sel1_d;
         sel2_q      <= sel2_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         pix_out_q   <= pix_out_d;
         ir_out_q    <= ir_out_d;
         pix_valid_q <= pix_valid_d;
         line_done_q <= line_done_d;
      end
   end

   assign pix_out   = pix_out_q;
   assign ir_out    = ir_out_q;
   assign pix_valid = pix_valid_q;
   assign line_done = line_done_q;
   assign err_op    = err_q;

endmodule

// File: tb/tb_data_process.sv
// Self-checking bench for data_process: beat-schedule model plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_data_process;

   localparam int N  = 8;
   localparam int LL = 18;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [2:0]      data_process_reg;
   logic            sram_sel1, sram_sel2;
   logic [N*16-1:0] QB_1, QB_2, Q1_ir, Q2_ir;
   logic            cmd_ready;
   logic [N*8-1:0]  pix_out, ir_out;
   logic            pix_valid, line_done, err_op;

   always #5 clk = ~clk;

   data_process #(.SRAM_NUM(N), .LINE_LEN(LL)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .data_process_reg (data_process_reg),
      .sram_sel1        (sram_sel1),
      .sram_sel2        (sram_sel2),
      .QB_1             (QB_1),
      .QB_2             (QB_2),
      .Q1_ir            (Q1_ir),
      .Q2_ir            (Q2_ir),
      .cmd_ready        (cmd_ready),
      .pix_out          (pix_out),
      .ir_out           (ir_out),
      .pix_valid        (pix_valid),
      .line_done        (line_done),
      .err_op           (err_op)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each accepted op schedules its beats onto the upcoming edges; a beat's bytes are
   // read from the SRAM word present at the op's first-beat edge.
   typedef struct {
      bit vld;
      int op;
      bit s1;
      bit s2;
      int idx;
   } ent_t;

   ent_t           sched[$];
   logic [15:0]    mw_pix[N];
   logic [15:0]    mw_ir[N];
   logic [N*8-1:0] e_pix, e_ir;
   bit             e_vld, e_done, e_err, e_rdy;
   int             busy, m_cnt;
   bit             armed = 1'b0;

   function automatic int nbeats(input int op);
      if (op >= 1 && op <= 3) return 3;
      if (op >= 4 && op <= 6) return 1;
      return 0;
   endfunction

   function automatic logic [7:0] pick(input int op, input int idx, input logic [15:0] w);
      case (op)
         2:       return (idx == 0) ? 8'h00 : (idx == 1) ? w[15:8] : w[7:0];
         3:       return (idx == 0) ? w[15:8] : (idx == 1) ? w[7:0] : 8'h00;
         5:       return w[15:8];
         6:       return w[7:0];
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge clk) begin
      ent_t cur;
      ent_t empty;
      bit   rdy;
      int   op_i;
      empty = '{vld: 1'b0, op: 0, s1: 1'b0, s2: 1'b0, idx: 0};
      if (!rst_n) begin
         sched.delete();
         busy   = 0;
         m_cnt  = 0;
         e_pix  = '0;
         e_ir   = '0;
         e_vld  = 1'b0;
         e_done = 1'b0;
         e_err  = 1'b0;
         armed  = 1'b1;
      end else begin
         cur = empty;
         if (sched.size() > 0) cur = sched.pop_front();
         e_vld  = cur.vld;
         e_done = 1'b0;
         if (cur.vld) begin
            if (cur.idx == 0) begin
               for (int k = 0; k < N; k++) begin
                  mw_pix[k] = cur.s1 ? QB_2[16*k +: 16] : QB_1[16*k +: 16];
                  mw_ir[k]  = cur.s2 ? Q2_ir[16*k +: 16] : Q1_ir[16*k +: 16];
               end
            end
            for (int k = 0; k < N; k++) begin
               e_pix[8*k +: 8] = pick(cur.op, cur.idx, mw_pix[k]);
               e_ir[8*k +: 8]  = pick(cur.op, cur.idx, mw_ir[k]);
            end
            e_done = (m_cnt == LL - 1);
            m_cnt  = e_done ? 0 : m_cnt + 1;
         end
         rdy  = (busy == 0);
         if (busy > 0) busy--;
         op_i = int'(data_process_reg);
         if (rdy && op_i != 0) begin
            if (op_i == 7) begin
               e_err = 1'b1;
            end else begin
               for (int i = 0; i < nbeats(op_i); i++) begin
                  while (sched.size() <= i) sched.push_back(empty);
                  sched[i] = '{vld: 1'b1, op: op_i, s1: sram_sel1, s2: sram_sel2, idx: i};
               end
               if (nbeats(op_i) == 3) busy = 2;
            end
         end
      end
      e_rdy = (busy == 0);
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("cyc_pix_valid", 64'(pix_valid), 64'(e_vld));
         chk("cyc_line_done", 64'(line_done), 64'(e_done));
         chk("cyc_cmd_ready", 64'(cmd_ready), 64'(e_rdy));
         chk("cyc_err_op",    64'(err_op),    64'(e_err));
         chk("cyc_pix_out",   64'(pix_out),   64'(e_pix));
         chk("cyc_ir_out",    64'(ir_out),    64'(e_ir));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble();
      for (int k = 0; k < N; k++) begin
         QB_1[16*k +: 16]  = 16'($urandom);
         QB_2[16*k +: 16]  = 16'($urandom);
         Q1_ir[16*k +: 16] = 16'($urandom);
         Q2_ir[16*k +: 16] = 16'($urandom);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      data_process_reg = 3'd0;
      sram_sel1 = 1'b0;
      sram_sel2 = 1'b0;
      QB_1 = '0; QB_2 = '0; Q1_ir = '0; Q2_ir = '0;
      tick(); tick();
      chk("rst_valid", 64'(pix_valid), 64'd0);
      chk("rst_ready", 64'(cmd_ready), 64'd1);
      chk("rst_pix",   64'(pix_out),   64'd0);
      chk("rst_err",   64'(err_op),    64'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_valid", 64'(pix_valid), 64'd0);

      // op5 front byte from FSRAM1
      scramble();
      QB_1[15:0] = 16'hA1B2;
      sram_sel1 = 1'b0;
      data_process_reg = 3'd5;
      tick();
      data_process_reg = 3'd0;
      tick();
      chk("t1_pix",       64'(pix_out[7:0]), 64'hA1);
      chk("t1_valid",     64'(pix_valid),    64'd1);
      chk("t1_model_pix", 64'(e_pix[7:0]),   64'hA1);
      scramble();
      tick();
      chk("t1_hold",      64'(pix_out[7:0]), 64'hA1);
      chk("t1_no_beat",   64'(pix_valid),    64'd0);

      // op2 pad-forward from FSRAM2; select changes after accept must not matter
      scramble();
      QB_2[15:0] = 16'h3C4D;
      sram_sel1 = 1'b1;
      data_process_reg = 3'd2;
      chk("t2_ready_pre", 64'(cmd_ready), 64'd1);
      tick();
      data_process_reg = 3'd0;
      sram_sel1 = 1'b0;
      chk("t2_busy1", 64'(cmd_ready), 64'd0);
      tick();
      chk("t2_b0",    64'(pix_out[7:0]), 64'h00);
      chk("t2_v0",    64'(pix_valid),    64'd1);
      chk("t2_busy2", 64'(cmd_ready),    64'd0);
      scramble();
      tick();
      chk("t2_b1",    64'(pix_out[7:0]), 64'h3C);
      chk("t2_ready", 64'(cmd_ready),    64'd1);
      chk("t2_model_b1", 64'(e_pix[7:0]), 64'h3C);
      tick();
      chk("t2_b2",    64'(pix_out[7:0]), 64'h4D);
      tick();
      chk("t2_end",   64'(pix_valid), 64'd0);

      // op3 pad-backward on IRSRAM1; op6 offered while busy is dropped
      scramble();
      Q1_ir[15:0] = 16'h1122;
      sram_sel2 = 1'b0;
      data_process_reg = 3'd3;
      tick();
      data_process_reg = 3'd6;
      tick();
      chk("t3_b0", 64'(ir_out[7:0]), 64'h11);
      tick();
      data_process_reg = 3'd0;
      chk("t3_b1", 64'(ir_out[7:0]), 64'h22);
      tick();
      chk("t3_b2", 64'(ir_out[7:0]), 64'h00);
      tick();
      chk("t3_no_4th", 64'(pix_valid), 64'd0);
      chk("t3_no_err", 64'(err_op),    64'd0);

      // mixed back-to-back: op2 -> op3 at EMIT3 -> op6 -> op4 -> op5
      scramble();
      sram_sel1 = 1'b1; sram_sel2 = 1'b1;
      data_process_reg = 3'd2;
      tick();
      data_process_reg = 3'd3; sram_sel1 = 1'b0;
      scramble(); tick();
      scramble(); tick();
      scramble(); tick();
      data_process_reg = 3'd6; sram_sel2 = 1'b0;
      for (int i = 0; i < 3; i++) begin scramble(); tick(); end
      data_process_reg = 3'd4;
      scramble(); tick();
      data_process_reg = 3'd5; sram_sel1 = 1'b1;
      scramble(); tick();
      data_process_reg = 3'd0;
      for (int i = 0; i < 3; i++) begin scramble(); tick(); end

      // line counting from a clean counter: op1 then 16 x op5, gap-free
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      sram_sel1 = 1'b0;
      data_process_reg = 3'd1;
      tick();
      data_process_reg = 3'd5;
      for (int i = 1; i <= 19; i++) begin
         scramble();
         tick();
         if (i == 18) data_process_reg = 3'd0;
         chk($sformatf("line_valid_%0d", i), 64'(pix_valid), 64'd1);
         chk($sformatf("line_done_%0d", i),  64'(line_done), (i == 18) ? 64'd1 : 64'd0);
      end
      tick();
      chk("line_tail", 64'(pix_valid), 64'd0);

      // illegal op, then reset in the middle of an op2
      data_process_reg = 3'd7;
      tick();
      data_process_reg = 3'd0;
      tick();
      chk("t6_err",      64'(err_op),    64'd1);
      chk("t6_no_beat",  64'(pix_valid), 64'd0);
      tick();
      chk("t6_err_held", 64'(err_op),    64'd1);
      scramble();
      data_process_reg = 3'd2;
      tick();
      data_process_reg = 3'd0;
      tick();
      chk("t6_mid_valid", 64'(pix_valid), 64'd1);
      rst_n = 1'b0;
      tick();
      chk("t6_rst_pix",   64'(pix_out),   64'd0);
      chk("t6_rst_ir",    64'(ir_out),    64'd0);
      chk("t6_rst_valid", 64'(pix_valid), 64'd0);
      chk("t6_rst_err",   64'(err_op),    64'd0);
      chk("t6_rst_ready", 64'(cmd_ready), 64'd1);
      rst_n = 1'b1;
      tick();
      chk("t6_post1", 64'(pix_valid), 64'd0);
      tick();
      chk("t6_post2", 64'(pix_valid), 64'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
